// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU sequencer and its PC unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Default widths: program counter / ROM address, and ROM word
    localparam int DEF_PC_W  = 12;
    localparam int DEF_ROM_W = 8;

    // Top bit of each nibble inside a ROM word: instr = [7:4], oprnd = [3:0]
    localparam int INSTR_HI = 7;
    localparam int OPR_HI   = 3;

    // Sequencer states; phase output is 1 only in ST_EXEC
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter with load-over-increment priority and modulo-2^PC_W wrap.
// Latency: pc updates one clk after the strobes; next_pc is the combinational preview.
// Backpressure: none; en = 0 freezes the counter regardless of strobes.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            incPC,
    input  logic            loadPC,
    input  logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc
);

    // Value pc takes at the next edge; also used for the breakpoint compare
    always_comb begin
        next_pc = pc;
        if (en) begin
            if (loadPC) begin
                next_pc = pc_target;
            end else if (incPC) begin
                next_pc = pc + PC_W'(1);
            end
        end
    end

    // PC register, synchronous active-low reset to address 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: PC, fetch register, phase, C/Z flags, run/step/breakpoint control.
// Latency: one instruction per 2 clk (FETCH then EXEC); halt requests act at the end of EXEC.
// Backpressure: none; run = 0 or a breakpoint parks the machine in HALT with exec_en low.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int ROM_W = DEF_ROM_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [ROM_W-1:0] rom_data,
    output logic [3:0]       instr,
    output logic [3:0]       oprnd,
    output logic             phase,
    output logic             cflag,
    output logic             zflag,
    input  logic             incPC,
    input  logic             loadPC,
    input  logic             loadF,
    input  logic [PC_W-1:0]  pc_target,
    input  logic             alu_c,
    input  logic             alu_z,
    output logic             exec_en,
    output logic             halted,
    output logic             bp_hit
);

    state_t          state;
    state_t          state_nxt;
    logic            run_q;
    logic            single;
    logic            single_nxt;
    logic            skip_bp;
    logic            skip_nxt;
    logic            bp_hit_nxt;
    logic            run_rise;
    logic            bp_trig;
    logic            pc_en;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;

    assign pc_en    = (state == ST_FETCH) || (state == ST_EXEC);
    assign rom_addr = pc;
    assign run_rise = run && !run_q;
    // Breakpoint looks at where the PC lands after this EXEC, unless we just resumed
    assign bp_trig  = bp_en && (next_pc == bp_addr) && !skip_bp;

    pc_unit #(
        .PC_W (PC_W)
    ) u_pc (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (pc_en),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .pc_target (pc_target),
        .pc        (pc),
        .next_pc   (next_pc)
    );

    // State register plus debug control bits (single-step, skip-bp, sticky bp_hit, run history)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_HALT;
            run_q   <= 1'b0;
            single  <= 1'b0;
            skip_bp <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_q   <= run;
            single  <= single_nxt;
            skip_bp <= skip_nxt;
            bp_hit  <= bp_hit_nxt;
        end
    end

    // Next-state logic; run beats step, breakpoint beats single-step for bp_hit
    always_comb begin
        state_nxt  = state;
        single_nxt = single;
        skip_nxt   = skip_bp;
        bp_hit_nxt = bp_hit;
        case (state)
            ST_HALT: begin
                if (run_rise || (run && !bp_hit)) begin
                    state_nxt  = ST_FETCH;
                    single_nxt = 1'b0;
                    skip_nxt   = 1'b1;
                    bp_hit_nxt = 1'b0;
                end else if (step && !run) begin
                    state_nxt  = ST_FETCH;
                    single_nxt = 1'b1;
                    skip_nxt   = 1'b1;
                    bp_hit_nxt = 1'b0;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                skip_nxt = 1'b0;
                if (single || !run || bp_trig) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                end
                if (bp_trig) begin
                    bp_hit_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    // Decoded status outputs
    always_comb begin
        phase   = (state == ST_EXEC);
        halted  = (state == ST_HALT);
        exec_en = (state != ST_HALT);
    end

    // Fetch register captures the ROM word during FETCH only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr <= 4'h0;
            oprnd <= 4'h0;
        end else if (state == ST_FETCH) begin
            instr <= rom_data[INSTR_HI -: 4];
            oprnd <= rom_data[OPR_HI -: 4];
        end
    end

    // Flag register loads from the ALU during EXEC only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cflag <= 1'b0;
            zflag <= 1'b0;
        end else if ((state == ST_EXEC) && loadF) begin
            cflag <= alu_c;
            zflag <= alu_z;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed bring-up sequences then random stimulus vs a reference model.
// Latency: expectation for each driven cycle is checked 1 time unit after the following posedge.
// Backpressure: n/a; expectations queue up and the monitor drains them every clock.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        bp_en = 1'b0;
    logic [11:0] bp_addr = 12'h000;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        cflag;
    logic        zflag;
    logic        incPC = 1'b0;
    logic        loadPC = 1'b0;
    logic        loadF = 1'b0;
    logic [11:0] pc_target = 12'h000;
    logic        alu_c = 1'b0;
    logic        alu_z = 1'b0;
    logic        exec_en;
    logic        halted;
    logic        bp_hit;

    logic [7:0]  rom [4096];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_W  (12),
        .ROM_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .step      (step),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .instr     (instr),
        .oprnd     (oprnd),
        .phase     (phase),
        .cflag     (cflag),
        .zflag     (zflag),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .loadF     (loadF),
        .pc_target (pc_target),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .exec_en   (exec_en),
        .halted    (halted),
        .bp_hit    (bp_hit)
    );

    // Observable snapshot: {pc, instr, oprnd, phase, cflag, zflag, halted, exec_en, bp_hit}
    logic [25:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // Reference model: "running" means not parked; "in_exec" means second half of an instruction
    bit        m_running, m_in_exec;
    logic [11:0] m_pc;
    logic [3:0]  m_instr, m_opr;
    bit        m_c, m_z, m_bph, m_single, m_skip, m_prev_run;

    // Values applied to breakpoint inputs at the next driven cycle
    bit          bp_en_n = 1'b0;
    logic [11:0] bp_addr_n = 12'h000;
    bit          run_l = 1'b0;

    function automatic logic [11:0] pc_after(input logic [11:0] p, input bit ld, input bit inc,
                                             input logic [11:0] tgt);
        if (ld) return tgt;
        if (inc) return p + 12'd1;
        return p;
    endfunction

    function automatic logic [25:0] snapshot_model();
        return {m_pc, m_instr, m_opr, m_in_exec, m_c, m_z, !m_running, m_running, m_bph};
    endfunction

    task automatic model_advance();
        logic [11:0] np;
        bit brk;
        if (!reset_n) begin
            m_running = 0; m_in_exec = 0; m_pc = 12'h000; m_instr = 4'h0; m_opr = 4'h0;
            m_c = 0; m_z = 0; m_bph = 0; m_single = 0; m_skip = 0; m_prev_run = 0;
            return;
        end
        if (!m_running) begin
            if (run && (!m_prev_run || !m_bph)) begin
                m_running = 1; m_in_exec = 0; m_single = 0; m_skip = 1; m_bph = 0;
            end else if (step && !run) begin
                m_running = 1; m_in_exec = 0; m_single = 1; m_skip = 1; m_bph = 0;
            end
        end else if (!m_in_exec) begin
            m_instr = rom[m_pc][7:4];
            m_opr   = rom[m_pc][3:0];
            m_pc = pc_after(m_pc, loadPC, incPC, pc_target);
            m_in_exec = 1;
        end else begin
            np = pc_after(m_pc, loadPC, incPC, pc_target);
            m_pc = np;
            if (loadF) begin m_c = alu_c; m_z = alu_z; end
            brk = bp_en && (np == bp_addr) && !m_skip;
            if (m_single || !run || brk) m_running = 0;
            if (brk) m_bph = 1;
            m_skip = 0;
            m_in_exec = 0;
        end
        m_prev_run = run;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected post-edge state
    task automatic cyc(input bit rst, input bit r, input bit s, input bit inc, input bit ld,
                       input bit lf, input logic [11:0] tgt, input bit c, input bit z);
        @(negedge clk);
        reset_n = rst; run = r; step = s; incPC = inc; loadPC = ld; loadF = lf;
        pc_target = tgt; alu_c = c; alu_z = z;
        bp_en = bp_en_n; bp_addr = bp_addr_n;
        model_advance();
        exp_q.push_back(snapshot_model());
    endtask

    // Decoder stub: increment during FETCH only, no jumps, no flag loads
    task automatic acyc(input bit r, input bit s);
        cyc(1, r, s, m_running && !m_in_exec, 0, 0, 12'h000, 0, 0);
    endtask

    // Monitor: compare DUT state against the oldest queued expectation
    initial begin
        logic [25:0] act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {rom_addr, instr, oprnd, phase, cflag, zflag, halted, exec_en, bp_hit};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL state @%0t: actual pc=%h i=%h o=%h ph=%b c=%b z=%b hlt=%b en=%b bp=%b required pc=%h i=%h o=%h ph=%b c=%b z=%b hlt=%b en=%b bp=%b",
                             $time, act[25:14], act[13:10], act[9:6], act[5], act[4], act[3], act[2], act[1], act[0],
                             e[25:14], e[13:10], e[9:6], e[5], e[4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h5A;

        // Reset, then free-run from address 0
        cyc(0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        for (int i = 0; i < 6; i++) acyc(1, 0);

        // Reach pc 0x123 with cflag set, then reset in the middle of EXEC
        while (m_in_exec) acyc(1, 0);
        cyc(1, 1, 0, 0, 1, 0, 12'h123, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 12'h000, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        cyc(0, 1, 0, 1, 1, 1, 12'h777, 1, 1);
        cyc(1, 1, 0, 0, 0, 0, 12'h000, 0, 0);

        // Jump priority in EXEC, then wrap at 0xFFF
        cyc(1, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        cyc(1, 1, 0, 1, 1, 0, 12'hABC, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 12'hFFF, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 12'h000, 0, 0);

        // Flag load ignored in FETCH, honoured in EXEC
        cyc(1, 1, 0, 1, 0, 1, 12'h000, 1, 0);
        cyc(1, 1, 0, 0, 0, 1, 12'h000, 1, 0);
        cyc(1, 1, 0, 1, 0, 1, 12'h000, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 12'h000, 0, 1);

        // Halt at 0x010; strobes ignored while halted
        cyc(1, 1, 0, 0, 1, 0, 12'h010, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 12'h000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 1, 12'h3C3, 1, 1);

        // Single-step one instruction, then another step
        acyc(0, 1);
        for (int i = 0; i < 4; i++) acyc(0, 0);
        acyc(0, 1);
        for (int i = 0; i < 3; i++) acyc(0, 0);

        // Breakpoint at 0x005 from reset with run held high
        bp_en_n = 1; bp_addr_n = 12'h005;
        cyc(0, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        for (int i = 0; i < 14; i++) acyc(1, 0);
        acyc(1, 1);
        acyc(1, 0);
        acyc(0, 0);
        // Resume at 0x005 with a jump-to-self: first arrival skipped, second one halts
        cyc(1, 1, 0, 0, 1, 0, 12'h005, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 12'h005, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 12'h000, 0, 0);
        acyc(0, 0);
        for (int i = 0; i < 10; i++) acyc(1, 0);

        // Random traffic with jumps near the wrap point and small breakpoint addresses
        run_l = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] tgt;
            if ($urandom_range(0, 19) == 0) run_l = !run_l;
            if ($urandom_range(0, 49) == 0) begin
                bp_en_n = 1'($urandom);
                bp_addr_n = 12'($urandom_range(0, 15));
            end
            tgt = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1))
                                              : 12'($urandom_range(0, 15));
            cyc($urandom_range(0, 199) != 0, run_l, $urandom_range(0, 7) == 0,
                1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom), tgt,
                1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/execute sequencer for the 4-bit CPU.
- Owns the program counter, the fetch register (instr/operand nibbles), the phase bit and the C/Z flag register.
- Feeds {instr, cflag, zflag, phase} to the microcode decoder and applies the decoder's incPC/loadPC/loadF strobes.
- Adds run/halt, single-step and one hardware breakpoint for bring-up on the board.

Parameters:
- PC_W, 12, program counter and ROM address width.
- ROM_W, 8, program ROM word width: instr = rom_data[7:4], oprnd = rom_data[3:0].

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = free-run, 0 = halt at next instruction boundary.
- step  in  1  single-cycle pulse; executes exactly one instruction while halted.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint address.
- rom_addr  out  PC_W  program ROM address (= pc).
- rom_data  in  ROM_W  program ROM data, combinational read.
- instr  out  4  fetch register high nibble, to the decoder.
- oprnd  out  4  fetch register low nibble, to the datapath.
- phase  out  1  0 = fetch, 1 = execute, to the decoder.
- cflag  out  1  carry flag, to the decoder.
- zflag  out  1  zero flag, to the decoder.
- incPC  in  1  from the decoder.
- loadPC  in  1  from the decoder.
- loadF  in  1  from the decoder.
- pc_target  in  PC_W  jump target from the datapath.
- alu_c  in  1  ALU carry.
- alu_z  in  1  ALU zero.
- exec_en  out  1  1 when not HALT; the datapath gates loadA/weRAM/loadO with it.
- halted  out  1  1 in HALT.
- bp_hit  out  1  sticky; 1 = halted by breakpoint.

Behaviour:
- Reset (reset_n = 0 at a clk edge), from any state including mid-instruction:
  - state = HALT; pc = 0; phase = 0; instr/oprnd = 0; cflag = zflag = 0.
  - bp_hit = 0; halted = 1; exec_en = 0; internal single-step and skip-bp flags cleared.
- States and phase:
  - HALT: phase = 0.
  - FETCH: phase = 0.
  - EXEC: phase = 1.
  - All registered; one state per clk.
- HALT transitions:
  - Rising edge of run (registered previous value), or run = 1 with bp_hit = 0 → FETCH, single = 0.
  - Else step = 1 → FETCH, single = 1.
  - Leaving HALT clears bp_hit and sets skip_bp.
- FETCH:
  - Latch {instr, oprnd} ← rom_data.
  - Apply the PC update.
  - → EXEC unconditionally.
- EXEC:
  - Apply the PC and flag updates.
  - Let next_pc be the PC value after this cycle's update.
  - → HALT if single = 1, or run = 0, or (bp_en = 1 and next_pc == bp_addr and skip_bp = 0). The breakpoint case also sets bp_hit = 1.
  - Otherwise → FETCH.
  - skip_bp clears at the end of every EXEC.
- PC update, FETCH and EXEC only:
  - loadPC = 1 → pc ← pc_target (loadPC wins over incPC).
  - Else incPC = 1 → pc ← pc + 1, mod 2^PC_W (0xFFF wraps to 0x000).
  - Else hold.
- Flag update: EXEC only; loadF = 1 → cflag ← alu_c, zflag ← alu_z. loadF in FETCH or HALT is ignored.
- In HALT, incPC/loadPC/loadF are ignored; pc, flags and the fetch register hold.
- Latency:
  - One instruction = 2 clk (FETCH + EXEC).
  - Halt request (run → 0) takes effect at the end of the current EXEC; an instruction is never cut mid-phase.
- Simultaneous events:
  - step while run = 1 is ignored.
  - run rising and step in the same HALT cycle: run wins.
  - Breakpoint and single-step in the same EXEC: HALT with bp_hit = 1.
- Breakpoint at the current pc on resume does not re-trigger (skip_bp); it triggers on the next arrival.

Decomposition:
- Shared package cpu_pkg:
  - State encoding constants ST_HALT = 2'd0, ST_FETCH = 2'd1, ST_EXEC = 2'd2.
  - Default PC_W = 12, ROM_W = 8.
  - Nibble field positions INSTR_HI = 7 and OPR_HI = 3.
- One natural sub-module, pc_unit: PC register with load/increment priority and wrap; emits next_pc for the breakpoint compare.
- State machine, fetch register, flags and debug logic stay in cpu_sequencer.

Test Plan:
- Reset mid-EXEC: pc = 0x123, cflag = 1; reset_n = 0 one clk → pc = 0, flags = 0, phase = 0, halted = 1, bp_hit = 0.
- Free-run: run = 1, ROM[0] = 0x5A, decoder stub incPC = 1 in FETCH only → instr = 0x5, oprnd = 0xA after the first FETCH; phase toggles 0,1,0,1; pc = 1 after FETCH, 2 after the second FETCH.
- Jump priority: EXEC with loadPC = 1, incPC = 1, pc_target = 0xABC → pc = 0xABC next clk. Separately, pc = 0xFFF with incPC = 1 → pc = 0x000.
- Flags: loadF = 1, alu_c = 1, alu_z = 0 during FETCH → flags unchanged; same during EXEC → cflag = 1, zflag = 0.
- Single-step: halted at pc = 0x010, one-clk step pulse → exactly one FETCH+EXEC, then halted = 1, pc = 0x011 (incPC in FETCH only).
- Breakpoint: bp_en = 1, bp_addr = 0x005, run = 1 from pc = 0 → HALT with pc = 0x005, bp_hit = 1, run still high. Toggle run 0→1 → bp_hit = 0, execution resumes past 0x005 without re-halting.
